// File: rtl/exe_mem_stage_if.sv
// EX/MEM stage bundle: EX-side inputs, ID-side hazard query and registered stage outputs.
// The master drives EX/ID inputs and observes results; the slave is the stage.
interface exe_mem_stage_if #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
);
    logic              stall;
    logic              flush;
    logic [1:0]        controlmem_in;
    logic              controlwb_in;
    logic [DATA_W-1:0] alu_in;
    logic [DATA_W-1:0] wdata_in;
    logic [REG_W-1:0]  wreg_in;
    logic [REG_W-1:0]  id_rs_in;
    logic [REG_W-1:0]  id_rt_in;
    logic              id_rs_used;
    logic              id_rt_used;

    logic              valid_out;
    logic              memread_out;
    logic              memwrite_out;
    logic              controlwb_out;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] wdata_out;
    logic [REG_W-1:0]  wreg_out;
    logic              illegal_out;
    logic              fwd_valid_out;
    logic              hazard_out;

    modport master (
        output stall, flush, controlmem_in, controlwb_in, alu_in, wdata_in, wreg_in,
               id_rs_in, id_rt_in, id_rs_used, id_rt_used,
        input  valid_out, memread_out, memwrite_out, controlwb_out, alu_out,
               wdata_out, wreg_out, illegal_out, fwd_valid_out, hazard_out
    );

    modport slave (
        input  stall, flush, controlmem_in, controlwb_in, alu_in, wdata_in, wreg_in,
               id_rs_in, id_rt_in, id_rs_used, id_rt_used,
        output valid_out, memread_out, memwrite_out, controlwb_out, alu_out,
               wdata_out, wreg_out, illegal_out, fwd_valid_out, hazard_out
    );
endinterface

// File: rtl/exe_mem_stage.sv
// EX/MEM pipeline register with stall hold, flush-to-bubble, memory-control decode,
// forwarding qualifier and load-use hazard; 1-edge latency, stall holds all state.
// EXE_MEM_NEGEDGE_EN defined: registers update on the falling edge of clk.
module exe_mem_stage #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
) (
    input  logic            clk,
    input  logic            rst,
    exe_mem_stage_if.slave  bus
);
    localparam logic [1:0] MEM_NONE    = 2'b00;
    localparam logic [1:0] MEM_READ    = 2'b01;
    localparam logic [1:0] MEM_WRITE   = 2'b10;
    localparam logic [1:0] MEM_ILLEGAL = 2'b11;

    logic              valid_q;
    logic              memread_q;
    logic              memwrite_q;
    logic              wb_q;
    logic              illegal_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] wdata_q;
    logic [REG_W-1:0]  wreg_q;

    logic              memread_d;
    logic              memwrite_d;
    logic              wb_d;
    logic              illegal_d;

    // An illegal encoding is kept in the pipe for reporting but stripped of all side effects.
    always_comb begin
        memread_d  = 1'b0;
        memwrite_d = 1'b0;
        wb_d       = bus.controlwb_in;
        illegal_d  = 1'b0;
        case (bus.controlmem_in)
            MEM_NONE:    ;
            MEM_READ:    memread_d  = 1'b1;
            MEM_WRITE:   memwrite_d = 1'b1;
            MEM_ILLEGAL: begin
                wb_d      = 1'b0;
                illegal_d = 1'b1;
            end
            default:     ;
        endcase
    end

`ifdef EXE_MEM_NEGEDGE_EN
    always_ff @(negedge clk) begin
`else
    always_ff @(posedge clk) begin
`endif
        if (!rst || bus.flush) begin
            valid_q    <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            wb_q       <= 1'b0;
            illegal_q  <= 1'b0;
            alu_q      <= '0;
            wdata_q    <= '0;
            wreg_q     <= '0;
        end else if (!bus.stall) begin
            valid_q    <= 1'b1;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            wb_q       <= wb_d;
            illegal_q  <= illegal_d;
            alu_q      <= bus.alu_in;
            wdata_q    <= bus.wdata_in;
            wreg_q     <= bus.wreg_in;
        end
    end

    assign bus.valid_out     = valid_q;
    assign bus.memread_out   = memread_q;
    assign bus.memwrite_out  = memwrite_q;
    assign bus.controlwb_out = wb_q;
    assign bus.illegal_out   = illegal_q;
    assign bus.alu_out       = alu_q;
    assign bus.wdata_out     = wdata_q;
    assign bus.wreg_out      = wreg_q;

    // A load's alu_out is only an address, so it must not be forwarded as the result.
    assign bus.fwd_valid_out = valid_q & wb_q & ~memread_q;

    logic rs_hit;
    logic rt_hit;
    assign rs_hit         = bus.id_rs_used & (bus.id_rs_in == wreg_q);
    assign rt_hit         = bus.id_rt_used & (bus.id_rt_in == wreg_q);
    assign bus.hazard_out = valid_q & memread_q & wb_q & (rs_hit | rt_hit);
endmodule
